baccarat_deal_fsm: RTL and testbench

//  Moore controller that sequences one baccarat hand on the card/score datapath: issues load strobes for

---
 rtl/baccarat_deal_fsm.sv | 121 ++++++++++++
 tb/tb_baccarat_deal_fsm.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_deal_fsm.sv
// Moore controller sequencing one baccarat hand: card load strobes, third-card rules, win lights.
// Optional ROUND_COUNT_EN adds a saturating count of completed hands (round_count).
module baccarat_deal_fsm #(
  parameter int unsigned NATURAL_MIN = 8,
  parameter int unsigned PLAYER_DRAW = 5
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  input  logic       new_round,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       clear_hand,
  output logic       player_win_light,
  output logic       dealer_win_light
`ifdef ROUND_COUNT_EN
  ,
  output logic [7:0] round_count
`endif
);

  typedef enum logic [3:0] {
    START, P1, D1, P2, D2, CHK, P3, CHKD, D3, DONE, CLR
  } state_t;

  state_t     state_q, state_d;
  logic       lp1_d, lp2_d, lp3_d, ld1_d, ld2_d, ld3_d, clr_d;
  logic [3:0] p3_val;
  logic       dealer_draws;
  logic       natural;

  // Face cards and tens count as zero for the dealer's third-card decision.
  assign p3_val  = (pcard3 >= 4'd10) ? 4'd0 : pcard3;
  assign natural = (pscore >= 4'(NATURAL_MIN)) || (dscore >= 4'(NATURAL_MIN));

  always_comb begin
    dealer_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
      4'd3:             dealer_draws = (p3_val != 4'd8);
      4'd4:             dealer_draws = (p3_val >= 4'd2) && (p3_val <= 4'd7);
      4'd5:             dealer_draws = (p3_val >= 4'd4) && (p3_val <= 4'd7);
      4'd6:             dealer_draws = (p3_val >= 4'd6) && (p3_val <= 4'd7);
      default:          dealer_draws = 1'b0;
    endcase
  end

  // Next state plus strobe decode of the next state, so the strobes come out of flops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      START: state_d = P1;
      P1:    state_d = D1;
      D1:    state_d = P2;
      P2:    state_d = D2;
      D2:    state_d = CHK;
      CHK: begin
        if (natural)                               state_d = DONE;
        else if (pscore <= 4'(PLAYER_DRAW))        state_d = P3;
        else if (dscore <= 4'd5)                   state_d = D3;
        else                                       state_d = DONE;
      end
      P3:    state_d = CHKD;
      CHKD:  state_d = dealer_draws ? D3 : DONE;
      D3:    state_d = DONE;
      DONE:  state_d = new_round ? CLR : DONE;
      CLR:   state_d = P1;
      default: state_d = START;
    endcase
    lp1_d = (state_d == P1);
    lp2_d = (state_d == P2);
    lp3_d = (state_d == P3);
    ld1_d = (state_d == D1);
    ld2_d = (state_d == D2);
    ld3_d = (state_d == D3);
    clr_d = (state_d == CLR);
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= START;
      load_pcard1 <= 1'b0;
      load_pcard2 <= 1'b0;
      load_pcard3 <= 1'b0;
      load_dcard1 <= 1'b0;
      load_dcard2 <= 1'b0;
      load_dcard3 <= 1'b0;
      clear_hand  <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_pcard1 <= lp1_d;
      load_pcard2 <= lp2_d;
      load_pcard3 <= lp3_d;
      load_dcard1 <= ld1_d;
      load_dcard2 <= ld2_d;
      load_dcard3 <= ld3_d;
      clear_hand  <= clr_d;
    end
  end

  // Lights follow the live scores while the hand is finished; a tie lights both.
  assign player_win_light = (state_q == DONE) && (pscore >= dscore);
  assign dealer_win_light = (state_q == DONE) && (dscore >= pscore);

`ifdef ROUND_COUNT_EN
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      round_count <= 8'd0;
    end else if ((state_d == DONE) && (state_q != DONE) && (round_count != 8'hFF)) begin
      round_count <= round_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_baccarat_deal_fsm.sv
// Scoreboard bench for baccarat_deal_fsm with a behavioural card-register/scorer model.
// Define ROUND_COUNT_EN to also exercise round_count.
module tb_baccarat_deal_fsm;

  logic       slow_clock = 1'b0;
  logic       resetb;
  logic [3:0] pscore, dscore, pcard3;
  logic       new_round;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       clear_hand, player_win_light, dealer_win_light;
`ifdef ROUND_COUNT_EN
  logic [7:0] round_count;
`endif

  baccarat_deal_fsm dut (
    .slow_clock(slow_clock), .resetb(resetb),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3), .new_round(new_round),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .clear_hand(clear_hand), .player_win_light(player_win_light),
    .dealer_win_light(dealer_win_light)
`ifdef ROUND_COUNT_EN
    , .round_count(round_count)
`endif
  );

  always #5 slow_clock = ~slow_clock;

  typedef struct {
    int p1, p2, p3, d1, d2, d3;
    int edge_n, n_p3, n_d3, pl, dl;
  } hand_t;

  int n_assert = 0;
  int n_fail   = 0;
  hand_t exp_q[$];
  hand_t hands[7];
  hand_t cur;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Datapath model: six card registers captured on the edge leaving each strobe state.
  logic [3:0] rp1, rp2, rp3, rd1, rd2, rd3;
  function automatic int cval(input logic [3:0] c);
    return (c >= 4'd10) ? 0 : int'(c);
  endfunction
  always @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      {rp1, rp2, rp3, rd1, rd2, rd3} <= '0;
    end else if (clear_hand) begin
      {rp1, rp2, rp3, rd1, rd2, rd3} <= '0;
    end else begin
      if (load_pcard1) rp1 <= 4'(cur.p1);
      if (load_pcard2) rp2 <= 4'(cur.p2);
      if (load_pcard3) rp3 <= 4'(cur.p3);
      if (load_dcard1) rd1 <= 4'(cur.d1);
      if (load_dcard2) rd2 <= 4'(cur.d2);
      if (load_dcard3) rd3 <= 4'(cur.d3);
    end
  end
  assign pscore = 4'((cval(rp1) + cval(rp2) + cval(rp3)) % 10);
  assign dscore = 4'((cval(rd1) + cval(rd2) + cval(rd3)) % 10);
  assign pcard3 = rp3;

  // Monitor: tracks each hand from load_pcard1 and checks it against the scoreboard at DONE.
  int    cyc = 0, p3n = 0, d3n = 0;
  bit    in_done = 0, prev_clear = 0;
  hand_t got;
  always @(negedge slow_clock) begin
    if (!resetb) begin
      in_done    = 0;
      prev_clear = 0;
    end else begin
      check("strobes_onehot0", int'($onehot0({load_pcard1, load_pcard2, load_pcard3,
            load_dcard1, load_dcard2, load_dcard3, clear_hand})), 1);
      if (prev_clear) check("pcard1_after_clear", int'(load_pcard1), 1);
      prev_clear = clear_hand;
      if (load_pcard1) begin
        cyc = 1; p3n = 0; d3n = 0; in_done = 0;
      end else begin
        cyc++;
      end
      if (load_pcard3) p3n++;
      if (load_dcard3) d3n++;
      if ((player_win_light || dealer_win_light) && !in_done) begin
        in_done = 1;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          got = exp_q.pop_front();
          check("done_edge", cyc, got.edge_n);
          check("pcard3_pulses", p3n, got.n_p3);
          check("dcard3_pulses", d3n, got.n_d3);
          check("player_light", int'(player_win_light), got.pl);
          check("dealer_light", int'(dealer_win_light), got.dl);
        end
      end else if (in_done && !clear_hand) begin
        check("hold_player_light", int'(player_win_light), got.pl);
        check("hold_dealer_light", int'(dealer_win_light), got.dl);
        check("hold_no_strobe", int'({load_pcard1, load_pcard2, load_pcard3,
              load_dcard1, load_dcard2, load_dcard3}), 0);
      end
      if (clear_hand) in_done = 0;
    end
  end

  function automatic hand_t mk(input int p1, p2, p3, d1, d2, d3, edge_n, n_p3, n_d3, pl, dl);
    hand_t h;
    h.p1 = p1; h.p2 = p2; h.p3 = p3; h.d1 = d1; h.d2 = d2; h.d3 = d3;
    h.edge_n = edge_n; h.n_p3 = n_p3; h.n_d3 = n_d3; h.pl = pl; h.dl = dl;
    return h;
  endfunction

  int done_cnt = 0;
  task automatic wait_done(input string name);
    int budget;
    budget = 20;
    @(negedge slow_clock);
    while (!(player_win_light || dealer_win_light) && budget > 0) begin
      @(negedge slow_clock);
      budget--;
    end
    if (budget == 0) check({name, "_timeout"}, 0, 1);
    done_cnt++;
`ifdef ROUND_COUNT_EN
    check("round_count", int'(round_count), done_cnt);
`endif
  endtask

  task automatic check_all_zero(input string name);
    check(name, int'({load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2,
          load_dcard3, clear_hand, player_win_light, dealer_win_light}), 0);
  endtask

  initial begin
    //            p1 p2 p3  d1 d2 d3  edge p3 d3 pl dl
    hands[0] = mk(5, 3, 0,  1, 2, 0,  6,   0, 0, 1, 0);  // player natural 8
    hands[1] = mk(2, 2, 8,  1, 2, 0,  8,   1, 0, 0, 1);  // player draws 8, dealer 3 stands
    hands[2] = mk(3, 3, 0,  2, 3, 2,  7,   0, 1, 0, 1);  // player stands 6, dealer 5 draws
    hands[3] = mk(1, 1, 13, 3, 3, 0,  8,   1, 0, 0, 1);  // dealer 6 vs king: stands
    hands[4] = mk(1, 1, 7,  3, 3, 1,  9,   1, 1, 1, 0);  // dealer 6 vs 7: draws
    hands[5] = mk(3, 4, 0,  10, 7, 0, 6,   0, 0, 1, 1);  // tie 7/7
    hands[6] = mk(2, 2, 0,  4, 5, 0,  6,   0, 0, 0, 1);  // dealer natural 9

    resetb    = 1'b0;
    new_round = 1'b0;
    cur       = hands[0];
    exp_q.push_back(hands[0]);
    #1;
    check_all_zero("reset_outputs");
`ifdef ROUND_COUNT_EN
    check("reset_round_count", int'(round_count), 0);
`endif
    @(negedge slow_clock);
    @(negedge slow_clock);
    resetb = 1'b1;

    for (int i = 0; i < 7; i++) begin
      wait_done("hand");
      repeat ((i == 5) ? 5 : 2) @(negedge slow_clock);
      if (i < 6) begin
        cur = hands[i + 1];
        exp_q.push_back(hands[i + 1]);
      end else begin
        cur = hands[3];
      end
      new_round = 1'b1;
      @(negedge slow_clock);
      new_round = 1'b0;
    end

    // Abort a drawing hand in P3 with an asynchronous reset.
    begin
      int budget;
      budget = 20;
      while (!load_pcard3 && budget > 0) begin
        @(negedge slow_clock);
        budget--;
      end
      check("reach_p3", int'(load_pcard3), 1);
    end
    #2 resetb = 1'b0;
    #1 check_all_zero("async_reset_p3");
`ifdef ROUND_COUNT_EN
    check("async_reset_round_count", int'(round_count), 0);
    done_cnt = 0;
`endif
    @(negedge slow_clock);
    exp_q.push_back(hands[3]);
    resetb = 1'b1;
    @(posedge slow_clock);
    #1 check("p1_after_release", int'(load_pcard1), 1);
    wait_done("post_reset_hand");
    repeat (2) @(negedge slow_clock);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
